// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: board clock and baud constants, frame
//            width and the receiver state encoding.
// Contents : CLK_HZ, BAUD, BIT_CYCLES, DATA_BITS, rx_state_t
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Board clock and line rate; the transmitter wrapper derives its bit
  // period from the same pair so both ends agree.
  localparam int CLK_HZ     = 27_000_000;
  localparam int BAUD       = 115_200;
  localparam int BIT_CYCLES = CLK_HZ / BAUD;

  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    WAIT  = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop synchronizer for a single asynchronous input.
// Ports    : i_clk  - destination clock
//            i_rst  - asynchronous active-high reset
//            i_d    - asynchronous input
//            o_q    - synchronized output (RESET_VAL while in reset)
// Revision : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, LSB first. Recovers bytes from the serial
//            line, strobes each good byte and flags framing errors.
// Ports    : i_clk   - system clock
//            i_rst   - asynchronous active-high reset
//            i_rxd   - serial line, idle high, asynchronous to i_clk
//            o_data  - last correctly received byte (held)
//            o_valid - one-cycle strobe, o_data updated this cycle
//            o_ferr  - one-cycle strobe, stop bit low, byte discarded
//            o_led   - high while a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int D = BIT_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_ferr,
  output logic       o_led
);

  // Mid-bit offset used once in START; afterwards every sample lands a full
  // bit period later, so all data and stop samples stay centred.
  localparam int H  = D / 2;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] C_START_LAST = CW'(H - 1);
  localparam logic [CW-1:0] C_BIT_LAST   = CW'(D - 1);
  localparam logic [BW-1:0] C_LAST_BIT   = BW'(DATA_BITS - 1);

  logic                  w_rxs;

  rx_state_t             r_state;
  rx_state_t             w_state_nxt;
  logic [CW-1:0]         r_cyc;
  logic [CW-1:0]         w_cyc_nxt;
  logic [BW-1:0]         r_bit;
  logic [BW-1:0]         w_bit_nxt;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  w_shift_nxt;
  logic [7:0]            r_data;
  logic [7:0]            w_data_nxt;
  logic                  r_valid;
  logic                  w_valid_nxt;
  logic                  r_ferr;
  logic                  w_ferr_nxt;
  logic                  r_led;

  sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync_rxd (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rxd),
    .o_q   (w_rxs)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cyc_nxt   = r_cyc;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        w_cyc_nxt = '0;
        if (!w_rxs) begin
          w_state_nxt = START;
        end
      end

      START: begin
        if (r_cyc == C_START_LAST) begin
          w_cyc_nxt = '0;
          w_bit_nxt = '0;
          // A line that is high again at mid-start was a glitch.
          w_state_nxt = w_rxs ? IDLE : DATA;
        end else begin
          w_cyc_nxt = r_cyc + CW'(1);
        end
      end

      DATA: begin
        if (r_cyc == C_BIT_LAST) begin
          w_cyc_nxt   = '0;
          w_shift_nxt = {w_rxs, r_shift[DATA_BITS-1:1]};
          if (r_bit == C_LAST_BIT) begin
            w_bit_nxt   = '0;
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end else begin
          w_cyc_nxt = r_cyc + CW'(1);
        end
      end

      STOP: begin
        if (r_cyc == C_BIT_LAST) begin
          w_cyc_nxt = '0;
          // Leaving at mid-stop-bit lets a start bit that follows directly
          // be caught without losing the next frame.
          if (w_rxs) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT;
          end
        end else begin
          w_cyc_nxt = r_cyc + CW'(1);
        end
      end

      WAIT: begin
        // Hold off until the line is released so a break is not mistaken
        // for a stream of start bits.
        w_cyc_nxt = '0;
        if (w_rxs) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_cyc_nxt   = '0;
        w_bit_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cyc   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_led   <= 1'b0;
    end else begin
      r_cyc   <= w_cyc_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      // Registered from the next state so the LED tracks the state register.
      r_led   <= (w_state_nxt != IDLE);
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_ferr  = r_ferr;
  assign o_led   = r_led;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Directed self-checking bench for uart_rx with D=5 and a 20 ns
//            clock; frames are bit-banged at 5 clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int D = 5;

  logic       i_clk;
  logic       i_rst;
  logic       i_rxd;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_ferr;
  logic       o_led;

  int errors = 0;
  int checks = 0;

  int cyc        = 0;
  int valid_cnt  = 0;
  int ferr_cnt   = 0;
  int both_cnt   = 0;
  int led_cnt    = 0;
  int t_valid    = 0;
  logic [7:0] rx_q [$];

  int t_start;
  int base_valid;
  int base_ferr;
  int base_led;

  uart_rx #(
    .D (D)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_rxd   (i_rxd),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ferr  (o_ferr),
    .o_led   (o_led)
  );

  initial i_clk = 1'b0;
  always #10 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (o_valid) begin
      rx_q.push_back(o_data);
      valid_cnt <= valid_cnt + 1;
      t_valid   <= cyc;
    end
    if (o_ferr)           ferr_cnt <= ferr_cnt + 1;
    if (o_valid && o_ferr) both_cnt <= both_cnt + 1;
    if (o_led)            led_cnt  <= led_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    i_rxd = v;
    repeat (D) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_v);
  endtask

  task automatic idle(input int n);
    i_rxd = 1'b1;
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    i_rxd = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_data",  {24'd0, o_data}, 32'h00);
    check("reset_valid", {31'd0, o_valid}, 32'd0);
    check("reset_ferr",  {31'd0, o_ferr},  32'd0);
    check("reset_led",   {31'd0, o_led},   32'd0);
    i_rst = 1'b0;
    idle(4);

    // Single frame 0x0A
    base_led = led_cnt;
    send_frame(8'h0A, 1'b1);
    idle(4);
    check("f0a_valid_cnt", valid_cnt, 1);
    check("f0a_data",      {24'd0, rx_q[0]}, 32'h0A);
    check("f0a_odata",     {24'd0, o_data},  32'h0A);
    check("f0a_ferr_cnt",  ferr_cnt, 0);
    check("f0a_latency_ok", ((t_valid - t_start) >= 49 && (t_valid - t_start) <= 51) ? 1 : 0, 1);
    check("f0a_led_cycles_ok", ((led_cnt - base_led) >= 45 && (led_cnt - base_led) <= 49) ? 1 : 0, 1);
    check("f0a_led_low",   {31'd0, o_led}, 32'd0);

    // Back-to-back 0x08, 0x55, 0xAA with no idle gap
    send_frame(8'h08, 1'b1);
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    idle(4);
    check("b2b_valid_cnt", valid_cnt, 4);
    check("b2b_first",     {24'd0, rx_q[1]}, 32'h08);
    check("b2b_second",    {24'd0, rx_q[2]}, 32'h55);
    check("b2b_third",     {24'd0, rx_q[3]}, 32'hAA);
    check("b2b_ferr_cnt",  ferr_cnt, 0);

    // Framing error: 0x3C with stop bit low, then line held low
    send_frame(8'h3C, 1'b0);
    i_rxd = 1'b0;
    repeat (20) @(posedge i_clk);
    #1;
    check("ferr_cnt",      ferr_cnt, 1);
    check("ferr_no_valid", valid_cnt, 4);
    check("ferr_data_held", {24'd0, o_data}, 32'hAA);
    check("ferr_led_wait", {31'd0, o_led}, 32'd1);
    idle(6);
    check("ferr_led_release", {31'd0, o_led}, 32'd0);
    send_frame(8'h41, 1'b1);
    idle(4);
    check("after_ferr_valid_cnt", valid_cnt, 5);
    check("after_ferr_data", {24'd0, o_data}, 32'h41);

    // One-clock glitch on an idle line
    base_valid = valid_cnt;
    base_ferr  = ferr_cnt;
    i_rxd = 1'b0;
    @(posedge i_clk);
    #1;
    idle(20);
    check("glitch_no_valid", valid_cnt, base_valid);
    check("glitch_no_ferr",  ferr_cnt,  base_ferr);
    check("glitch_data",     {24'd0, o_data}, 32'h41);
    check("glitch_led",      {31'd0, o_led},  32'd0);

    // Reset during data bit 4 of 0xF0
    base_valid = valid_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    i_rxd = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check("pre_rst_led", {31'd0, o_led}, 32'd1);
    i_rst = 1'b1;
    #1;
    check("rst_mid_data",  {24'd0, o_data}, 32'h00);
    check("rst_mid_led",   {31'd0, o_led},  32'd0);
    check("rst_mid_valid", {31'd0, o_valid}, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    idle(25);
    check("rst_no_valid", valid_cnt, base_valid);
    check("rst_no_ferr",  ferr_cnt, 1);
    send_frame(8'h0A, 1'b1);
    idle(4);
    check("post_rst_valid_cnt", valid_cnt, base_valid + 1);
    check("post_rst_data", {24'd0, o_data}, 32'h0A);

    // Transmitter loopback pattern: counts 10 then 8
    send_frame(8'h0A, 1'b1);
    idle(4);
    check("loop_10_valid_cnt", valid_cnt, base_valid + 2);
    check("loop_10_data", {24'd0, o_data}, 32'h0A);
    send_frame(8'h08, 1'b1);
    idle(4);
    check("loop_8_valid_cnt", valid_cnt, base_valid + 3);
    check("loop_8_data", {24'd0, o_data}, 32'h08);

    check("never_both_strobes", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive-side counterpart of the team's button-count UART transmitter.
- Samples the asynchronous serial line and recovers 8N1 frames (LSB first).
- Presents each received byte with a one-cycle valid strobe and flags framing errors.
- Drives a busy LED.
- Sits between the board RX pin and downstream display/count logic, and also serves as the loopback checker for the transmitter in simulation.

Parameters:
- D, 234, clock cycles per bit (27 MHz / 115200); legal range D >= 4; simulation uses D=5.
- H, D/2, sample offset within a bit in cycles (mid-bit); derived, not overridden.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset; one clock; asynchronous, active-high
- i_rxd  input  1  serial line, idle high, asynchronous to i_clk
- o_data  output  8  last correctly received byte; held until the next good frame
- o_valid  output  1  one-cycle strobe: o_data updated this cycle
- o_ferr  output  1  one-cycle strobe: stop bit sampled low, byte discarded
- o_led  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (async, i_rst=1): state=IDLE, synchronizer flops=1, bit counter=0, cycle counter=0, shift reg=0, o_data=0x00, o_valid=0, o_ferr=0, o_led=0. Reset mid-frame aborts immediately; no strobe is emitted.
- i_rxd passes through a 2-flop synchronizer (reset value 1); all decisions use the synced value rxs.
- States: IDLE, START, DATA, STOP, WAIT.
- IDLE: when rxs==0, go to START and clear the cycle counter.
- START: count cycles. At count H-1, sample rxs:
  - rxs==0: go to DATA with cycle counter=0 and bit counter=0.
  - rxs==1: glitch; return to IDLE with no strobe.
- DATA: at cycle count D-1, sample rxs into shift[7] and shift right (LSB first), clear the cycle counter and increment the bit counter. After the 8th sample, go to STOP.
- STOP: at cycle count D-1, sample rxs:
  - rxs==1: o_data<=shift, o_valid=1 for exactly one cycle, go to IDLE.
  - rxs==0: o_ferr=1 for exactly one cycle, o_data unchanged, go to WAIT.
- WAIT: stay until rxs==1, then go to IDLE. A break or stuck-low line does not re-trigger reception.
- Latency: o_valid rises 2 + H + 9*D + 1 cycles (+/-1) after the i_rxd start falling edge. With D=5 this is 50 +/-1 cycles.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit that immediately follows a stop bit is detected with no lost frame.
- o_valid and o_ferr are never high in the same cycle. Neither is asserted outside the STOP exit cycle.
- Counters: cycle counter is clog2(D) bits; bit counter is 3 bits plus terminal detect. No wrap past D-1.
- o_led = (state != IDLE), registered.

Decomposition:
- Package uart_pkg:
  - state enum/localparams (IDLE, START, DATA, STOP, WAIT)
  - DATA_BITS=8
  - shared CLK_HZ/BAUD constants, also used by the transmitter wrapper
- Sub-module sync2: 2-flop synchronizer, reset value as a parameter, async active-high reset. Instantiated once for i_rxd.
- FSM, counters and shift register stay in uart_rx.

Test Plan:
All with D=5, 20 ns clock; bytes are driven by a bench-side 8N1 bit-banger at 5 clocks/bit.
- Send 0x0A -> one o_valid pulse, o_data=0x0A, o_ferr never high, o_led high for about 47 cycles then low.
- Send 0x08, then 0x55 and 0xAA back-to-back with no idle gap -> three o_valid pulses in order, o_data=0x08, 0x55, 0xAA.
- Frame 0x3C with the stop bit driven low -> o_ferr pulses once, o_valid stays 0, o_data holds its previous value. FSM stays in WAIT (o_led=1) until the line returns high; a following 0x41 is received correctly.
- Single-cycle low glitch (1 clock) on idle line -> returns to IDLE from START, no o_valid/o_ferr, o_data unchanged.
- Assert i_rst for 1 cycle during DATA bit 4 of 0xF0 -> all outputs 0 immediately, no strobe. A subsequent 0x0A is received as 0x0A.
- Loopback from the transmitter wrapper after 10 then 8 count presses -> o_data=0x0A, then 0x08, each with one o_valid pulse.
